// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_mult_pkg                                                    |
// | Purpose  : Shared types and helpers for the sequential shift-add           |
// |            multiplier: FSM state encoding and a constant log2 function     |
// |            used to size the step counter.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling log2, evaluated at elaboration time. Returns at least 1 so a
  // counter sized with it never collapses to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_mult_if                                                     |
// | Purpose  : Start/done handshake bundle between a requester and the         |
// |            sequential multiplier.                                          |
// | Ports    : start        - request a new multiplication                     |
// |            multiplicand - operand A (WIDTH bits)                           |
// |            multiplier   - operand B (WIDTH bits)                           |
// |            busy         - multiplication in progress                       |
// |            done         - one-cycle pulse, product valid                   |
// |            product      - last completed result (2*WIDTH bits)             |
// |            master modport drives requests, slave modport is the engine.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seq_mult_if #(
  parameter int WIDTH = 4
);

  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface
`default_nettype wire

// File: rtl/seq_mult_rca_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rca_adder                                                       |
// | Purpose  : WIDTH-bit ripple-carry adder built from per-bit full-adder      |
// |            cells.                                                          |
// | Ports    : a, b  - addends (WIDTH bits)                                    |
// |            cin   - carry in                                                |
// |            sum   - WIDTH-bit sum                                           |
// |            cout  - carry out of the top bit                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rca_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa_cell
    logic half_sum;
    assign half_sum     = a[i] ^ b[i];
    assign sum[i]       = half_sum ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (half_sum & carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_mult                                                        |
// | Purpose  : Unsigned WIDTH x WIDTH sequential shift-add multiplier. One     |
// |            add-and-shift step per cycle, WIDTH steps per product.          |
// | Ports    : clk   - rising-edge clock                                       |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - seq_mult_if.slave (start, operands, busy, done,         |
// |                    product)                                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_if.slave      bus
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     areg;
  // {carry, upper half, lower half}
  logic [2*WIDTH:0]     preg;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH-1:0]     upper;
  logic [WIDTH-1:0]     lower;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 step_c;
  logic [WIDTH-1:0]     step_upper;
  logic [2*WIDTH:0]     preg_shift;
  logic                 last_step;

  assign upper     = preg[2*WIDTH-1:WIDTH];
  assign lower     = preg[WIDTH-1:0];
  assign last_step = (cnt == LAST_STEP);

  rca_adder #(
    .WIDTH (WIDTH)
  ) u_acc_adder (
    .a    (upper),
    .b    (areg),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One add-and-shift step. When the multiplier LSB is clear the upper half
  // passes through; the carry slot of preg is always 0 between steps, so
  // reusing it as the pass-through carry keeps c=0.
  always_comb begin
    step_c     = preg[2*WIDTH];
    step_upper = upper;
    if (preg[0]) begin
      step_c     = add_cout;
      step_upper = add_sum;
    end
    preg_shift = {1'b0, step_c, step_upper, lower[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start in DONE is accepted directly for back-to-back
  // operation; a start in RUN is simply not looked at.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, step counter, shift register, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg      <= '0;
      preg      <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            areg <= bus.multiplicand;
            preg <= {1'b0, {WIDTH{1'b0}}, bus.multiplier};
            cnt  <= '0;
          end
        end
        RUN: begin
          preg <= preg_shift;
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            product_r <= preg_shift[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register only.
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_mult                                                     |
// | Purpose  : Self-checking bench for seq_mult with a 4-bit and an 8-bit      |
// |            instance; expected products are queued when a request is       |
// |            driven and compared when done pulses.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_mult;

  typedef struct {
    bit          wide;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(4)) bus4 ();
  seq_mult_if #(.WIDTH(8)) bus8 ();

  seq_mult #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int done4_cnt = 0;
  logic [15:0] exp4_q[$];
  logic [15:0] exp8_q[$];

  always @(posedge clk) cycle = cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus4.done === 1'b1) begin
        done4_cnt++;
        if (exp4_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w4_unexpected_done: actual done=1 required no pending result");
        end else begin
          chk("w4_scoreboard_product", 32'(bus4.product), 32'(exp4_q.pop_front()));
        end
      end
      if (bus8.done === 1'b1) begin
        if (exp8_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w8_unexpected_done: actual done=1 required no pending result");
        end else begin
          chk("w8_scoreboard_product", 32'(bus8.product), 32'(exp8_q.pop_front()));
        end
      end
    end
  end

  // Single request with full latency and handshake checks.
  task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int lat;
    lat = wide ? 8 : 4;
    @(negedge clk);
    if (wide) begin
      bus8.start = 1'b1;
      bus8.multiplicand = a;
      bus8.multiplier = b;
      exp8_q.push_back(exp);
    end else begin
      bus4.start = 1'b1;
      bus4.multiplicand = a[3:0];
      bus4.multiplier = b[3:0];
      exp4_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      chk("run_busy", 32'(wide ? bus8.busy : bus4.busy), 32'd1);
      chk("run_no_done", 32'(wide ? bus8.done : bus4.done), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("latency_done", 32'(wide ? bus8.done : bus4.done), 32'd1);
    chk("latency_busy_low", 32'(wide ? bus8.busy : bus4.busy), 32'd0);
    chk("latency_product", wide ? 32'(bus8.product) : 32'(bus4.product), 32'(exp));
    @(posedge clk);
    #1;
    chk("hold_done_low", 32'(wide ? bus8.done : bus4.done), 32'd0);
    chk("hold_product", wide ? 32'(bus8.product) : 32'(bus4.product), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [3:0]  bb_a[4];
    logic [3:0]  bb_b[4];
    logic [15:0] bb_e[4];
    int d0;
    int prev;
    bit found;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{1'b0, 8'd15,  8'd15,  16'd225};
    vecs[2] = '{1'b0, 8'd0,   8'd9,   16'd0};
    vecs[3] = '{1'b0, 8'd9,   8'd0,   16'd0};
    vecs[4] = '{1'b0, 8'd1,   8'd1,   16'd1};
    vecs[5] = '{1'b1, 8'd255, 8'd255, 16'd65025};
    vecs[6] = '{1'b1, 8'd200, 8'd3,   16'd600};

    bb_a = '{4'd3, 4'd6, 4'd15, 4'd2};
    bb_b = '{4'd5, 4'd7, 4'd14, 4'd9};
    bb_e = '{16'd15, 16'd42, 16'd210, 16'd18};

    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
    bus8.start = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;

    // Reset state, visible before any clock edge.
    #3;
    chk("reset_busy4", 32'(bus4.busy), 32'd0);
    chk("reset_done4", 32'(bus4.done), 32'd0);
    chk("reset_product4", 32'(bus4.product), 32'd0);
    chk("reset_busy8", 32'(bus8.busy), 32'd0);
    chk("reset_product8", 32'(bus8.product), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single multiplications.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // A start raised during RUN is ignored.
    d0 = done4_cnt;
    @(negedge clk);
    bus4.start = 1'b1; bus4.multiplicand = 4'd13; bus4.multiplier = 4'd11;
    exp4_q.push_back(16'd143);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    @(posedge clk);
    #1;
    bus4.start = 1'b1; bus4.multiplicand = 4'd2; bus4.multiplier = 4'd2;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_start_done_count", 32'(done4_cnt - d0), 32'd1);
    chk("ignored_start_product", 32'(bus4.product), 32'd143);

    // Back-to-back with start held high; operands change on each done cycle.
    @(negedge clk);
    bus4.start = 1'b1; bus4.multiplicand = bb_a[0]; bus4.multiplier = bb_b[0];
    exp4_q.push_back(bb_e[0]);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        if (bus4.done === 1'b1) found = 1'b1;
      end
      chk("b2b_done_seen", 32'(found), 32'd1);
      if (!found) break;
      if (i > 0) chk("b2b_interval", 32'(cycle - prev), 32'd5);
      prev = cycle;
      if (i < 3) begin
        bus4.multiplicand = bb_a[i + 1];
        bus4.multiplier = bb_b[i + 1];
        exp4_q.push_back(bb_e[i + 1]);
      end else begin
        bus4.start = 1'b0;
      end
    end

    // Reset during RUN aborts the operation immediately.
    @(negedge clk);
    bus4.start = 1'b1; bus4.multiplicand = 4'd7; bus4.multiplier = 4'd7;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(bus4.busy), 32'd1);
    chk("abort_hold_during_run", 32'(bus4.product), 32'd18);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus4.busy), 32'd0);
    chk("abort_done", 32'(bus4.done), 32'd0);
    chk("abort_product", 32'(bus4.product), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'd3, 8'd5, 16'd15);

    repeat (6) @(posedge clk);
    #1;
    chk("w4_queue_empty", 32'(exp4_q.size()), 32'd0);
    chk("w8_queue_empty", 32'(exp8_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
